decoder38_rr_arbiter: RTL and testbench
=======================================

// Module: decoder38_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one 3-to-8 decoder (chip-select decoder38) among 8 requesters.
//   Picks one requester and drives the decoder's enable and 3-bit select to produce its one-hot grant.
//   Holds the grant until the owner finishes, then inserts a dead gap so two selects never overlap.
//   Sits between requesting masters and the decoder38 instance in the exp1 datapath.
// PARAMETERS
//   GAP_CYCLES  1   idle cycles forced between grants, legal range 1..15 (EN low, GNT all zero)
//   MAX_HOLD    16  watchdog limit in cycles per grant; used only with ARB_TIMEOUT_EN, legal range 2..255
// PORTS
//   CLK      in   1  clock, all state updates on rising edge
//   RST      in   1  synchronous reset, active-high
//   REQ      in   8  request per master, level-held until served
//   DONE     in   1  pulse from current owner: transfer complete
//   EN       out  1  decoder enable (to decoder38 EN)
//   SEL      out  3  decoder select {Ip2,Ip1,Ip0}, SEL[2] = MSB
//   GNT      out  8  one-hot grant = EN ? (8'b1 << SEL) : 8'h00
//   BUSY     out  1  high in GRANT and GAP states
//   TIMEOUT  out  1  1-cycle pulse when watchdog revokes a grant; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset: next edge with RST=1 forces EN=0, SEL=3'd0, GNT=8'h00, BUSY=0, TIMEOUT=0, PTR=3'd0, state IDLE.
//     Applies from any state, including mid-grant; EN drops at that edge with no gap.
//   All outputs are registered except GNT, a combinational decode of registered EN/SEL.
//   PTR is a 3-bit round-robin pointer: index with top priority in the next arbitration.
//   States:
//     IDLE: if |REQ, winner = first set bit scanning PTR, PTR+1, ... PTR+7 (mod 8).
//       At that edge: SEL <= winner, EN <= 1, go GRANT. Latency: REQ seen at edge n -> EN=1 after edge n.
//       If REQ==0, stay IDLE with EN=0.
//     GRANT: EN=1 and SEL stable for the whole grant.
//       Release condition: DONE=1, or REQ[SEL]=0 (requester withdrew).
//       On release, at that edge: EN <= 0, PTR <= SEL+1 (3'd7 wraps to 3'd0), GAP counter <= GAP_CYCLES-1, go GAP.
//       DONE and REQ[SEL] drop in the same cycle count as one release.
//       DONE while not in GRANT is ignored.
//     GAP: EN=0, BUSY=1. Counter decrements each edge; at 0, go IDLE.
//       Requests arriving during GAP are arbitrated only in IDLE, so EN rises >= GAP_CYCLES+1 edges after release.
//   Simultaneous requests: only PTR order matters, arrival order is ignored.
//     Owner re-asserting REQ after release has lowest priority vs other pending requesters.
//   SEL holds its last value in IDLE/GAP, so the decoder input only changes when EN=0 or at grant start.
//   REQ bits may change at any time; only REQ[SEL] is sampled during GRANT.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     8-bit hold counter clears at grant start and increments each GRANT cycle.
//     When the counter reaches MAX_HOLD-1 without release, the next edge forces release exactly as DONE would
//       (PTR advance, GAP) and pulses TIMEOUT=1 for one cycle.
//     A real release in the same cycle takes precedence: no TIMEOUT pulse.
//   ARB_TIMEOUT_EN undefined: no counter, TIMEOUT tied 0; a grant lasts until DONE or REQ withdrawal.
// TESTING
//   T1 reset: RST=1 two cycles with REQ=8'hFF -> EN=0, GNT=8'h00, BUSY=0, SEL=0.
//   T2 single: REQ=8'h10 -> one edge later EN=1, SEL=3'd4, GNT=8'h10.
//      DONE pulse -> EN=0 next edge, BUSY=1 for GAP_CYCLES, then IDLE.
//   T3 rotation: REQ=8'hFF held, DONE pulsed each grant -> SEL sequence 0,1,2,...,7,0.
//      GNT never has two bits set; at least 1 zero cycle between grants.
//   T4 wrap/priority: PTR=7 (after serving 6), REQ=8'h41 -> grant 0 before 6.
//      Then REQ=8'h40 -> grant 6.
//   T5 withdraw/mid-reset: grant 3 active, drop REQ[3] -> release + PTR=4.
//      Separately, RST during GRANT -> EN=0 same edge, PTR=0.
//   T6 (ARB_TIMEOUT_EN, MAX_HOLD=16): REQ=8'h02 held, no DONE -> EN high exactly 16 cycles.
//      TIMEOUT pulses once, GAP follows, then the grant is re-issued to 1.

Source files
------------

// File: rtl/decoder38_rr_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 chip-select decoder among 8 requesters.
// Optional grant watchdog is enabled by defining ARB_TIMEOUT_EN.

module decoder38_rr_arbiter #(
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned MAX_HOLD   = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] REQ,
   input  logic       DONE,
   output logic       EN,
   output logic [2:0] SEL,
   output logic [7:0] GNT,
   output logic       BUSY,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e     state_q;
   logic [2:0] ptr_q;
   logic [3:0] gap_q;
   logic [2:0] winner;
   logic       any_req;
   logic       owner_release;
   logic       release_now;

   // Scan from the pointer upward with wrap; the first set request wins.
   always_comb begin
      logic [2:0] idx;
      winner  = ptr_q;
      any_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!any_req && REQ[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   assign owner_release = DONE | ~REQ[SEL];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q;
   logic       hold_expired;

   assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));
   assign release_now  = owner_release | hold_expired;
`else
   logic unused_max_hold;

   assign unused_max_hold = ^8'(MAX_HOLD);
   assign release_now     = owner_release;
   assign TIMEOUT         = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         ptr_q   <= 3'd0;
         gap_q   <= 4'd0;
         EN      <= 1'b0;
         SEL     <= 3'd0;
         BUSY    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= 8'd0;
         TIMEOUT <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         TIMEOUT <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  SEL     <= winner;
                  EN      <= 1'b1;
                  BUSY    <= 1'b1;
                  state_q <= StGrant;
`ifdef ARB_TIMEOUT_EN
                  hold_q  <= 8'd0;
`endif
               end
            end
            StGrant: begin
               if (release_now) begin
                  // SEL is left untouched so the decoder input only moves while EN is low.
                  EN      <= 1'b0;
                  ptr_q   <= SEL + 3'd1;
                  gap_q   <= 4'(GAP_CYCLES - 1);
                  state_q <= StGap;
`ifdef ARB_TIMEOUT_EN
                  TIMEOUT <= ~owner_release;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  hold_q <= hold_q + 8'd1;
               end
`endif
            end
            StGap: begin
               if (gap_q == 4'd0) begin
                  BUSY    <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               EN      <= 1'b0;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

   assign GNT = EN ? (8'b1 << SEL) : 8'h00;

endmodule

// File: tb/tb_decoder38_rr_arbiter.sv
// Directed self-checking bench for decoder38_rr_arbiter (GAP_CYCLES=1, MAX_HOLD=16).

module tb_decoder38_rr_arbiter;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] REQ;
   logic       DONE;
   logic       EN;
   logic [2:0] SEL;
   logic [7:0] GNT;
   logic       BUSY;
   logic       TIMEOUT;

   int checks   = 0;
   int failures = 0;
   int n;

   always #5 CLK = ~CLK;

   decoder38_rr_arbiter #(
      .GAP_CYCLES(1),
      .MAX_HOLD  (16)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .REQ    (REQ),
      .DONE   (DONE),
      .EN     (EN),
      .SEL    (SEL),
      .GNT    (GNT),
      .BUSY   (BUSY),
      .TIMEOUT(TIMEOUT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_en(input int limit, output int cnt);
      cnt = 0;
      while (EN !== 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      // T1: reset with all requests pending
      RST  = 1'b1;
      REQ  = 8'hFF;
      DONE = 1'b0;
      tick();
      tick();
      chk("rst_en", 32'(EN), 32'd0);
      chk("rst_gnt", 32'(GNT), 32'h00);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_sel", 32'(SEL), 32'd0);
      chk("rst_timeout", 32'(TIMEOUT), 32'd0);

      // T2: single requester
      RST = 1'b0;
      REQ = 8'h10;
      tick();
      chk("single_en", 32'(EN), 32'd1);
      chk("single_sel", 32'(SEL), 32'd4);
      chk("single_gnt", 32'(GNT), 32'h10);
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      REQ  = 8'h00;
      chk("single_rel_en", 32'(EN), 32'd0);
      chk("single_rel_busy", 32'(BUSY), 32'd1);
      chk("single_rel_gnt", 32'(GNT), 32'h00);
      tick();
      chk("single_idle_busy", 32'(BUSY), 32'd0);
      chk("single_idle_sel_hold", 32'(SEL), 32'd4);
      tick();
      chk("single_no_req_en", 32'(EN), 32'd0);

      // T3: rotation with everybody requesting, from a fresh pointer
      RST = 1'b1;
      tick();
      RST = 1'b0;
      REQ = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         wait_en(8, n);
         chk("rot_wait", 32'(n), (k == 0) ? 32'd1 : 32'd2);
         chk("rot_sel", 32'(SEL), 32'(k % 8));
         chk("rot_onehot", 32'($onehot(GNT)), 32'd1);
         chk("rot_gnt", 32'(GNT), 32'(8'b1 << (k % 8)));
         DONE = 1'b1;
         tick();
         DONE = 1'b0;
         chk("rot_gap_gnt", 32'(GNT), 32'h00);
      end

      // T4: serve 6 to set PTR=7, then 0 must beat 6
      REQ = 8'h40;
      wait_en(8, n);
      chk("wrap_first_sel", 32'(SEL), 32'd6);
      REQ  = 8'h41;
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      tick();
      tick();
      chk("wrap_en", 32'(EN), 32'd1);
      chk("wrap_sel", 32'(SEL), 32'd0);
      REQ = 8'h40;
      tick();
      chk("wrap_withdraw_en", 32'(EN), 32'd0);
      tick();
      tick();
      chk("wrap_then6_sel", 32'(SEL), 32'd6);
      chk("wrap_then6_en", 32'(EN), 32'd1);

      // T5: withdrawal from grant 3, then pointer must sit at 4
      REQ = 8'h08;
      tick();
      tick();
      tick();
      chk("wd_grant3_sel", 32'(SEL), 32'd3);
      chk("wd_grant3_en", 32'(EN), 32'd1);
      REQ = 8'h00;
      tick();
      chk("wd_rel_en", 32'(EN), 32'd0);
      chk("wd_rel_busy", 32'(BUSY), 32'd1);
      REQ = 8'h18;
      tick();
      tick();
      chk("wd_ptr4_sel", 32'(SEL), 32'd4);
      chk("wd_ptr4_en", 32'(EN), 32'd1);

      // Reset mid-grant: EN drops at that edge, pointer returns to 0
      RST = 1'b1;
      tick();
      chk("midrst_en", 32'(EN), 32'd0);
      chk("midrst_busy", 32'(BUSY), 32'd0);
      chk("midrst_sel", 32'(SEL), 32'd0);
      RST = 1'b0;
      REQ = 8'h81;
      tick();
      chk("midrst_ptr0_sel", 32'(SEL), 32'd0);
      chk("midrst_ptr0_en", 32'(EN), 32'd1);

      // T6: requester 1 holds without DONE
      REQ  = 8'h02;
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      tick();
      tick();
      chk("hold_sel", 32'(SEL), 32'd1);
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (EN === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("to_hold_len", 32'(n), 32'd16);
      chk("to_pulse", 32'(TIMEOUT), 32'd1);
      chk("to_busy", 32'(BUSY), 32'd1);
      tick();
      chk("to_pulse_end", 32'(TIMEOUT), 32'd0);
      tick();
      chk("to_regrant_en", 32'(EN), 32'd1);
      chk("to_regrant_sel", 32'(SEL), 32'd1);
`else
      for (int k = 0; k < 20; k++) tick();
      chk("nto_still_en", 32'(EN), 32'd1);
      chk("nto_timeout", 32'(TIMEOUT), 32'd0);
      chk("nto_gnt", 32'(GNT), 32'h02);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
